// File: rtl/dsm_upconv_core.sv
// ---------------------------------------------------------------------------
// dsm_upconv_core
//
// Purpose:
//   Digital up-converter front end for a 1-bit output stage. Baseband
//   samples arrive through a valid/ready handshake. Each sample is held for
//   OSR clocks (zero-order-hold interpolation) and multiplied by a
//   selectable digital LO (bypass, fs/4, fs/2). The mixer output drives a
//   1st- or 2nd-order delta-sigma modulator, which produces the pwm bit
//   stream for the analogue output filter.
//
// Parameters:
//   DW    : input/mixer sample width, signed two's complement
//   OSR   : clocks per input sample, 2..256
//   ORDER : modulator order, 1 or 2
//   IW    : integrator width, signed (must be >= DW)
//
// Ports:
//   clock        in   system clock, all logic on the rising edge
//   reset        in   asynchronous active-low reset
//   enable       in   1 = run, 0 = freeze every state element
//   lo_mode[1:0] in   00 bypass, 01 fs/4, 10 fs/2, 11 reserved (bypass)
//   vin[DW-1:0]  in   signed baseband sample
//   vin_valid    in   vin holds a sample
//   vin_ready    out  core accepts a sample this cycle (from registered phase)
//   mix_o        out  registered mixer output, for observation
//   pwm          out  registered modulator bit
//   underrun_cnt out  saturating count of ready slots with no sample offered
//
// Build option:
//   DSM_DITHER_EN : when defined, a 16-bit Fibonacci LFSR
//                   (x^16+x^14+x^13+x^11+1, seed 16'hACE1) adds +/-1 of
//                   dither to the first integrator on every enabled clock.
// ---------------------------------------------------------------------------
module dsm_upconv_core #(
   parameter int DW    = 20,
   parameter int OSR   = 4,
   parameter int ORDER = 1,
   parameter int IW    = DW + 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [1:0]           lo_mode,
   input  logic signed [DW-1:0] vin,
   input  logic                 vin_valid,
   output logic                 vin_ready,
   output logic signed [DW-1:0] mix_o,
   output logic                 pwm,
   output logic [7:0]           underrun_cnt
);

   // ------------------------------------------------------------------
   // Local constants
   // ------------------------------------------------------------------
   localparam int PW = (OSR > 2) ? $clog2(OSR) : 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(OSR - 1);
   localparam logic [PW-1:0] PHASE_ONE  = PW'(1'b1);
   localparam logic [PW-1:0] PHASE_ZERO = {PW{1'b0}};

   // Sums are formed two bits wider than the integrators so that
   // i + mix - fb (+ dither) can never wrap before it is clamped.
   localparam int SW = IW + 2;

   localparam logic signed [DW-1:0] MIX_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] MIX_MIN = {1'b1, {(DW-1){1'b0}}};

   // Full-scale feedback magnitude 2^(DW-1)-1, expressed at sum width.
   localparam logic signed [SW-1:0] FS_POS = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [SW-1:0] FS_NEG = -FS_POS;

   // IW-bit signed range limits, expressed at sum width.
   localparam logic signed [SW-1:0] I_MAX = {{(SW-IW+1){1'b0}}, {(IW-1){1'b1}}};
   localparam logic signed [SW-1:0] I_MIN = {{(SW-IW+1){1'b1}}, {(IW-1){1'b0}}};

   // LO weight encoding used between the selector and the mixer.
   typedef enum logic [1:0] {
      W_POS  = 2'b00,
      W_ZERO = 2'b01,
      W_NEG  = 2'b10
   } weight_t;

   // ------------------------------------------------------------------
   // Helper functions
   // ------------------------------------------------------------------
   // Clamp a wide sum to the IW-bit signed integrator range.
   function automatic logic signed [IW-1:0] sat_iw(input logic signed [SW-1:0] v);
      logic signed [IW-1:0] r;
      if (v > I_MAX) begin
         r = I_MAX[IW-1:0];
      end else if (v < I_MIN) begin
         r = I_MIN[IW-1:0];
      end else begin
         r = v[IW-1:0];
      end
      return r;
   endfunction

   // Negate a DW-bit sample; the most-negative code maps to +max instead
   // of wrapping back onto itself.
   function automatic logic signed [DW-1:0] neg_sat(input logic signed [DW-1:0] v);
      logic signed [DW-1:0] r;
      if (v == MIX_MIN) begin
         r = MIX_MAX;
      end else begin
         r = -v;
      end
      return r;
   endfunction

   // Sign-extend an IW-bit integrator value to sum width.
   function automatic logic signed [SW-1:0] ext_iw(input logic signed [IW-1:0] v);
      return {{(SW-IW){v[IW-1]}}, v};
   endfunction

   // Sign-extend a DW-bit sample to sum width.
   function automatic logic signed [SW-1:0] ext_dw(input logic signed [DW-1:0] v);
      return {{(SW-DW){v[DW-1]}}, v};
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [PW-1:0]        phase_q,    phase_d;
   logic [1:0]           lo_cnt_q,   lo_cnt_d;
   logic signed [DW-1:0] held_q,     held_d;
   logic signed [DW-1:0] mix_q,      mix_d;
   logic signed [IW-1:0] i1_q,       i1_d;
   logic signed [IW-1:0] i2_q,       i2_d;
   logic                 pwm_q,      pwm_d;
   logic [7:0]           underrun_q, underrun_d;

   logic                 ready_s;
   weight_t              weight_s;
   logic signed [SW-1:0] fb_s;
   logic signed [SW-1:0] dith_s;
   logic signed [SW-1:0] sum1_s;
   logic signed [SW-1:0] sum2_s;

   // Ready is a pure decode of the registered phase, gated by enable, so
   // dropping enable on a ready cycle suppresses that load.
   assign ready_s = enable && (phase_q == PHASE_LAST);

`ifdef DSM_DITHER_EN
   logic [15:0] lfsr_q, lfsr_d;
   logic        lfsr_fb_s;

   // Dither source: Fibonacci LFSR, taps 16/14/13/11, advances when enabled.
   always_comb begin
      lfsr_fb_s = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
      if (enable) begin
         lfsr_d = {lfsr_q[14:0], lfsr_fb_s};
      end else begin
         lfsr_d = lfsr_q;
      end
      if (lfsr_q[0]) begin
         dith_s = {{(SW-1){1'b0}}, 1'b1};
      end else begin
         dith_s = {SW{1'b1}};
      end
   end

   // LFSR register, seeded on reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   // No dither: the first integrator update carries no extra term.
   assign dith_s = {SW{1'b0}};
`endif

   // Sample-rate control: phase counter, load/underrun bookkeeping, LO count.
   always_comb begin
      phase_d    = phase_q;
      lo_cnt_d   = lo_cnt_q;
      held_d     = held_q;
      underrun_d = underrun_q;
      if (enable) begin
         if (phase_q == PHASE_LAST) begin
            phase_d = PHASE_ZERO;
         end else begin
            phase_d = phase_q + PHASE_ONE;
         end
         lo_cnt_d = lo_cnt_q + 2'd1;
         if (ready_s && vin_valid) begin
            held_d = vin;
         end else if (ready_s && (underrun_q != 8'hFF)) begin
            // Ready slot with nothing offered: keep the old sample.
            underrun_d = underrun_q + 8'd1;
         end else begin
            held_d     = held_q;
            underrun_d = underrun_q;
         end
      end else begin
         phase_d    = phase_q;
         lo_cnt_d   = lo_cnt_q;
         held_d     = held_q;
         underrun_d = underrun_q;
      end
   end

   // LO weight select from the registered LO count and the live lo_mode.
   always_comb begin
      weight_s = W_POS;
      case (lo_mode)
         2'b01: begin
            case (lo_cnt_q)
               2'd0:    weight_s = W_POS;
               2'd1:    weight_s = W_ZERO;
               2'd2:    weight_s = W_NEG;
               2'd3:    weight_s = W_ZERO;
               default: weight_s = W_ZERO;
            endcase
         end
         2'b10: begin
            if (lo_cnt_q[0]) begin
               weight_s = W_NEG;
            end else begin
               weight_s = W_POS;
            end
         end
         default: weight_s = W_POS;   // 00 bypass, 11 reserved
      endcase
   end

   // Mixer: apply the LO weight to the held sample.
   always_comb begin
      mix_d = mix_q;
      if (enable) begin
         case (weight_s)
            W_POS:   mix_d = held_q;
            W_NEG:   mix_d = neg_sat(held_q);
            W_ZERO:  mix_d = {DW{1'b0}};
            default: mix_d = {DW{1'b0}};
         endcase
      end else begin
         mix_d = mix_q;
      end
   end

   // Modulator: integrators fed by the registered mixer output with
   // full-scale feedback selected by the registered pwm bit.
   always_comb begin
      i1_d  = i1_q;
      i2_d  = i2_q;
      pwm_d = pwm_q;
      if (pwm_q) begin
         fb_s = FS_POS;
      end else begin
         fb_s = FS_NEG;
      end
      sum1_s = ext_iw(i1_q) + ext_dw(mix_q) - fb_s + dith_s;
      sum2_s = {SW{1'b0}};
      if (enable) begin
         i1_d = sat_iw(sum1_s);
         if (ORDER == 2) begin
            // Second stage integrates the already-updated first stage.
            sum2_s = ext_iw(i2_q) + ext_iw(i1_d) - fb_s;
            i2_d   = sat_iw(sum2_s);
            pwm_d  = ~i2_d[IW-1];
         end else begin
            i2_d  = i2_q;
            pwm_d = ~i1_d[IW-1];
         end
      end else begin
         i1_d  = i1_q;
         i2_d  = i2_q;
         pwm_d = pwm_q;
      end
   end

   // Core state registers with asynchronous clear.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         phase_q    <= PHASE_ZERO;
         lo_cnt_q   <= 2'd0;
         held_q     <= {DW{1'b0}};
         mix_q      <= {DW{1'b0}};
         i1_q       <= {IW{1'b0}};
         i2_q       <= {IW{1'b0}};
         pwm_q      <= 1'b0;
         underrun_q <= 8'd0;
      end else begin
         phase_q    <= phase_d;
         lo_cnt_q   <= lo_cnt_d;
         held_q     <= held_d;
         mix_q      <= mix_d;
         i1_q       <= i1_d;
         i2_q       <= i2_d;
         pwm_q      <= pwm_d;
         underrun_q <= underrun_d;
      end
   end

   assign vin_ready    = ready_s;
   assign mix_o        = mix_q;
   assign pwm          = pwm_q;
   assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_dsm_upconv_core.sv
// ---------------------------------------------------------------------------
// tb_dsm_upconv_core
//
// Directed bench for dsm_upconv_core (DW=20, OSR=4). Two instances share
// all inputs: u_dut1 is ORDER=1, u_dut2 is ORDER=2. Expected values are
// hand-derived; 'k' counts enabled clock edges since reset release, which
// is what the LO count and the zero-input pwm pattern follow.
// ---------------------------------------------------------------------------
module tb_dsm_upconv_core;

   localparam int DW = 20;

   logic                 clock     = 1'b0;
   logic                 reset     = 1'b0;
   logic                 enable    = 1'b0;
   logic [1:0]           lo_mode   = 2'b00;
   logic signed [DW-1:0] vin       = '0;
   logic                 vin_valid = 1'b0;

   logic                 ready1, ready2;
   logic signed [DW-1:0] mix1, mix2;
   logic                 pwm1, pwm2;
   logic [7:0]           und1, und2;

   int total = 0;
   int bad   = 0;
   int k     = 0;

   dsm_upconv_core #(.DW(DW), .OSR(4), .ORDER(1)) u_dut1 (
      .clock(clock), .reset(reset), .enable(enable), .lo_mode(lo_mode),
      .vin(vin), .vin_valid(vin_valid), .vin_ready(ready1),
      .mix_o(mix1), .pwm(pwm1), .underrun_cnt(und1)
   );

   dsm_upconv_core #(.DW(DW), .OSR(4), .ORDER(2)) u_dut2 (
      .clock(clock), .reset(reset), .enable(enable), .lo_mode(lo_mode),
      .vin(vin), .vin_valid(vin_valid), .vin_ready(ready2),
      .mix_o(mix2), .pwm(pwm2), .underrun_cnt(und2)
   );

   always #5 clock = ~clock;

   // One clock: wait for the edge, count it if enabled, settle 1 time unit.
   task automatic tick();
      @(posedge clock);
      if (enable && reset) k++;
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
      total++;
      assert (obs >= lo && obs <= hi) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   // fs/4 mixer output after enabled edge kk: weight follows (kk-1) mod 4.
   function automatic logic signed [63:0] fs4_exp(input int kk, input int x);
      logic signed [63:0] r;
      case ((kk - 1) % 4)
         0:       r = x;
         2:       r = (x == -524288) ? 64'sd524287 : -x;
         default: r = 64'sd0;
      endcase
      return r;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt1;
      int cnt2;
      bit found;
      // ---------------- reset state ----------------
      enable = 1'b1; vin_valid = 1'b1; vin = '0; lo_mode = 2'b00;
      #1;
      chk("rst_pwm",   pwm1,  0);
      chk("rst_pwm2",  pwm2,  0);
      chk("rst_mix",   mix1,  0);
      chk("rst_ready", ready1, 0);
      chk("rst_und",   und1,  0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;

      // ---------------- zero input: sequence and first ready -------------
      // i1: FS,0,-FS,0,-FS,... so pwm 1,1,0,1,0,1 from the first edge.
      tick(); chk("zero_seq1", pwm1, 1); chk("ready_e1", ready1, 0);
      tick(); chk("zero_seq2", pwm1, 1); chk("ready_e2", ready1, 0);
      tick(); chk("zero_seq3", pwm1, 0); chk("ready_e3", ready1, 1);
      tick(); chk("zero_seq4", pwm1, 1);
      tick(); chk("zero_seq5", pwm1, 0);
      tick(); chk("zero_seq6", pwm1, 1);
      repeat (2) tick();
      cnt1 = 0;
      for (int i = 0; i < 1024; i++) begin
         tick();
         cnt1 += int'(pwm1);
      end
      chk_range("ones_zero", cnt1, 511, 513);

      // ---------------- enable freeze (zero input) ----------------
      // With zero input pwm is 1 after even enabled edges, 0 after odd.
      enable = 1'b0; vin_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("frz_ready", ready1, 0);
         chk("frz_pwm",   pwm1, (k % 2 == 0) ? 1 : 0);
         chk("frz_mix",   mix1, 0);
         chk("frz_und",   und1, 0);
      end
      enable = 1'b1; vin_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("resume_pwm", pwm1, (k % 2 == 0) ? 1 : 0);
      end

      // ---------------- half scale, ORDER 1 and 2 ----------------
      vin = 20'sd262144;
      repeat (8) tick();
      cnt1 = 0; cnt2 = 0;
      for (int i = 0; i < 1024; i++) begin
         tick();
         cnt1 += int'(pwm1);
         cnt2 += int'(pwm2);
      end
      chk_range("ones_half_o1", cnt1, 766, 770);
      chk_range("ones_half_o2", cnt2, 766, 770);

      // ---------------- fs/4 mixing ----------------
      lo_mode = 2'b01; vin = 20'sd1000;
      repeat (8) tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("fs4_mix", mix1, fs4_exp(k, 1000));
      end
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("fs4_frz_mix",   mix1, fs4_exp(k, 1000));
         chk("fs4_frz_ready", ready1, 0);
      end
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("fs4_resume_mix", mix1, fs4_exp(k, 1000));
      end
      vin = 20'h80000;
      repeat (8) tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("fs4_neg_mix", mix1, fs4_exp(k, -524288));
      end

      // ---------------- underrun and handshake ----------------
      lo_mode = 2'b00; vin = 20'sd12345; vin_valid = 1'b1;
      repeat (8) tick();
      chk("und_base_mix", mix1, 12345);
      chk("und_base_cnt", und1, 0);
      vin_valid = 1'b0; vin = 20'sd777;
      repeat (12) tick();
      chk("und3_cnt", und1, 3);
      chk("und3_mix", mix1, 12345);
      vin = 20'sd999;
      for (int i = 0; i < 8; i++) begin
         vin_valid = ~ready1;
         tick();
      end
      chk("offslot_cnt", und1, 5);
      chk("offslot_mix", mix1, 12345);
      vin_valid = 1'b0;
      repeat (1200) tick();
      chk("und_sat", und1, 255);

      // ---------------- asynchronous reset mid-operation ----------------
      vin_valid = 1'b1; vin = 20'sd12345;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (pwm1) found = 1'b1;
      end
      chk("pwm_high_found", found, 1);
      #2 reset = 1'b0;
      #1;
      chk("arst_pwm",   pwm1,  0);
      chk("arst_mix",   mix1,  0);
      chk("arst_ready", ready1, 0);
      chk("arst_und",   und1,  0);
      @(posedge clock);
      #1 reset = 1'b1;
      k = 0;
      tick(); chk("rel_ready1", ready1, 0); chk("rel_pwm1", pwm1, 1);
      tick(); chk("rel_ready2", ready1, 0);
      tick(); chk("rel_ready3", ready1, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
